// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-fetch, data-memory and byte-wide
// RAM signals that the memory arbiter sits between.
//   if_*  : 4-byte fetch request / completion from the IF stage
//   mem_* : 1/2/4-byte load/store request / completion from the MEM stage
//   ram_* : single byte-wide RAM port driven by the arbiter
// Modports:
//   slave  : the arbiter's view (serves IF/MEM, drives the RAM port)
//   master : the environment's view (requesters and the RAM)
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_data;
    logic                  if_done;

    logic                  mem_req;
    logic                  mem_we;
    logic [2:0]            mem_len;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_done;

    logic [7:0]            ram_din;
    logic [7:0]            ram_dout;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic                  ram_wr;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the single byte-wide RAM port and shares it between
// instruction fetch (IF) and the data memory stage (MEM). Multi-byte accesses
// are serialised into byte transfers and assembled little-endian; the whole
// word is returned to the requester with a one-cycle done pulse.
// Ports:
//   clk         : system clock, all state changes on rising edge
//   rst         : synchronous active-high reset (wins over rdy)
//   rdy         : global enable; low freezes all state and outputs
//   jump_or_not : taken jump; ignores if_req in IDLE, aborts an IF read
//   bus         : mem_arbiter_if.slave (IF, MEM and RAM signal groups)
//
// state | meaning
// IDLE  | arbitrating; MEM has priority over IF
// READ  | collecting one RAM byte per cycle into rd_buf
// WRITE | emitting one store byte per cycle on the RAM port
// DONE  | done pulse visible for one cycle, requests not sampled
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          jump_or_not,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [2:0]            len, len_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] wdata, wdata_nxt;
    logic [DATA_WIDTH-1:0] rd_buf, rd_buf_nxt, rd_buf_cap;
    logic [1:0]            byte_idx;

    logic [DATA_WIDTH-1:0] if_data_nxt, mem_rdata_nxt;
    logic                  if_done_nxt, mem_done_nxt;
    logic [7:0]            ram_dout_nxt;
    logic [ADDR_WIDTH-1:0] ram_a_nxt;
    logic                  ram_wr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWNER_IF;
            base          <= '0;
            len           <= '0;
            cnt           <= '0;
            wdata         <= '0;
            rd_buf        <= '0;
            bus.if_data   <= '0;
            bus.if_done   <= 1'b0;
            bus.mem_rdata <= '0;
            bus.mem_done  <= 1'b0;
            bus.ram_dout  <= '0;
            bus.ram_a     <= '0;
            bus.ram_wr    <= 1'b0;
        end else if (rdy) begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            base          <= base_nxt;
            len           <= len_nxt;
            cnt           <= cnt_nxt;
            wdata         <= wdata_nxt;
            rd_buf        <= rd_buf_nxt;
            bus.if_data   <= if_data_nxt;
            bus.if_done   <= if_done_nxt;
            bus.mem_rdata <= mem_rdata_nxt;
            bus.mem_done  <= mem_done_nxt;
            bus.ram_dout  <= ram_dout_nxt;
            bus.ram_a     <= ram_a_nxt;
            bus.ram_wr    <= ram_wr_nxt;
        end
    end

    // Byte captured this cycle belongs to the address issued for cnt-1.
    always_comb begin
        byte_idx   = cnt[1:0] - 2'd1;
        rd_buf_cap = rd_buf;
        rd_buf_cap[{byte_idx, 3'b000} +: 8] = bus.ram_din;
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        base_nxt      = base;
        len_nxt       = len;
        cnt_nxt       = cnt;
        wdata_nxt     = wdata;
        rd_buf_nxt    = rd_buf;
        if_data_nxt   = bus.if_data;
        if_done_nxt   = 1'b0;
        mem_rdata_nxt = bus.mem_rdata;
        mem_done_nxt  = 1'b0;
        ram_dout_nxt  = bus.ram_dout;
        ram_a_nxt     = bus.ram_a;
        ram_wr_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    owner_nxt = OWNER_MEM;
                    base_nxt  = bus.mem_addr;
                    len_nxt   = bus.mem_len;
                    wdata_nxt = bus.mem_wdata;
                    ram_a_nxt = bus.mem_addr;
                    cnt_nxt   = 3'd1;
                    if (bus.mem_we) begin
                        state_nxt    = WRITE;
                        ram_dout_nxt = bus.mem_wdata[7:0];
                        ram_wr_nxt   = 1'b1;
                    end else begin
                        state_nxt  = READ;
                        rd_buf_nxt = '0;
                    end
                end else if (bus.if_req && !jump_or_not) begin
                    owner_nxt  = OWNER_IF;
                    base_nxt   = bus.if_addr;
                    len_nxt    = 3'd4;
                    ram_a_nxt  = bus.if_addr;
                    cnt_nxt    = 3'd1;
                    rd_buf_nxt = '0;
                    state_nxt  = READ;
                end
            end
            READ: begin
                if (owner == OWNER_IF && jump_or_not) begin
                    state_nxt = IDLE;
                end else begin
                    rd_buf_nxt = rd_buf_cap;
                    if (cnt < len) begin
                        ram_a_nxt = base + ADDR_WIDTH'(cnt);
                        cnt_nxt   = cnt + 3'd1;
                    end else begin
                        state_nxt = DONE;
                        if (owner == OWNER_MEM) begin
                            mem_rdata_nxt = rd_buf_cap;
                            mem_done_nxt  = 1'b1;
                        end else begin
                            if_data_nxt = rd_buf_cap;
                            if_done_nxt = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt < len) begin
                    ram_a_nxt    = base + ADDR_WIDTH'(cnt);
                    ram_dout_nxt = wdata[{cnt[1:0], 3'b000} +: 8];
                    ram_wr_nxt   = 1'b1;
                    cnt_nxt      = cnt + 3'd1;
                end else begin
                    state_nxt    = DONE;
                    mem_done_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    a_mem_len_legal: assert property (@(posedge clk) disable iff (rst)
        (rdy && state == IDLE && bus.mem_req) |->
        (bus.mem_len == 3'd1 || bus.mem_len == 3'd2 || bus.mem_len == 3'd4));

    a_ram_wr_only_in_write: assert property (@(posedge clk) disable iff (rst)
        bus.ram_wr |-> (state == WRITE));
endmodule
